exception_controller: RTL and testbench
=======================================

Name: exception_controller

Overview:
- Sequences exception and interrupt entry for the cpu32e2 core.
- Prioritises synchronous exceptions and masked interrupt lines, then drives exceptionPending and the 5-bit cause into the system register block.
- Computes the handler vector from isrBaseAddress and hands it to fetch through a valid/ack handshake.
- Tracks a single level of handler nesting until return-from-interrupt.

Parameters:
NUM_IRQ, 16, number of interrupt lines; legal range 1..16; line i gated by exceptionMask[i].
NUM_SYNC, 4, number of synchronous exception sources; legal range 1..16.
VECTOR_SHIFT, 2, log2 byte stride between vector slots.

Ports:
clk  in  1  core clock; all state changes on posedge
reset  in  1  reset, synchronous, active-high
irq  in  NUM_IRQ  interrupt request lines; level-sensitive by default
syncException  in  NUM_SYNC  synchronous exception strobes from the execute stage; bit 0 is the highest priority
interruptEnable  in  1  global interrupt enable from the system block
exceptionMask  in  16  per-line enable; 1 = line enabled
isrBaseAddress  in  32  handler table base
instructionDone  in  1  instruction boundary strobe
returnFromInterrupt  in  1  reti retired
vectorAck  in  1  fetch accepted the vector
exceptionPending  out  1  suppresses architectural writes
cause  out  5  captured cause code
vectorValid  out  1  vector offered to fetch
vectorAddress  out  32  handler address
clearInterruptEnable  out  1  one-cycle strobe; system block applies RESET_INTEN
inHandler  out  1  handler active
doubleFault  out  1  sticky fault flag

Behaviour:
- Reset values (synchronous, reset wins over every other input):
  - state = IDLE.
  - All outputs 0; cause = 0; vectorAddress = 0.
- Cause encoding:
  - Synchronous exception s: cause = s.
  - IRQ line i: cause = 16 + i.
- Eligible interrupt: irq[i] && exceptionMask[i] && interruptEnable.
- Priority:
  - Any syncException bit beats every interrupt.
  - Within each group, the lowest index wins.
- vectorAddress = isrBaseAddress + (cause << VECTOR_SHIFT).
  - Computed modulo 2^32; wrap-around is silent.
  - Registered at capture and held stable while vectorValid = 1.
- IDLE:
  - Any syncException bit -> CAPTURE in the same cycle; the instruction is aborted.
  - Else an eligible irq AND instructionDone -> CAPTURE.
  - Interrupts are only taken at instruction boundaries.
- CAPTURE (1 cycle):
  - Latch cause and vectorAddress.
  - exceptionPending = 1.
  - Pulse clearInterruptEnable.
  - Next state: VECTOR.
- VECTOR:
  - vectorValid = 1 and exceptionPending = 1.
  - Hold until vectorAck; on vectorAck -> ACTIVE.
  - New requests arriving in this state are ignored; they are not queued.
- ACTIVE:
  - inHandler = 1; exceptionPending = 0.
  - Interrupts are ignored regardless of interruptEnable (nesting depth 1).
  - returnFromInterrupt -> IDLE on the next cycle.
  - syncException -> FAULT; takes precedence over a simultaneous returnFromInterrupt.
- FAULT:
  - doubleFault = 1 and exceptionPending = 1.
  - cause = 31.
  - Exits only by reset.
- Latency: a sync exception in cycle N gives exceptionPending = 1 in cycle N+1 and vectorValid = 1 in cycle N+2.
- irq deasserting after capture does not cancel entry.

Optional Feature:
- Macro: IRQ_LATCH_EN.
- Defined:
  - A rising edge on irq[i] sets pending[i].
  - pending[i] is cleared in CAPTURE when line i is dispatched.
  - Eligibility uses pending[i] instead of irq[i].
  - Pending bits accumulate in every state, including ACTIVE.
  - Reset clears all pending bits.
- Undefined: level-sensitive lines with no pending register.

Test Plan:
- syncException = 4'b0100 in IDLE -> cause = 2, vectorAddress = isrBaseAddress + 8, vectorValid in cycle N+2, clearInterruptEnable pulses once.
- irq[3] = 1, exceptionMask = 16'h0008, interruptEnable = 1, instructionDone = 1 -> cause = 19, vectorAddress = base + 76.
- irq[3] and irq[5] plus syncException[1] in the same cycle -> cause = 1; then set interruptEnable = 0 -> no interrupt is ever taken.
- Hold vectorAck low for 5 cycles -> vectorValid and vectorAddress stable throughout; isrBaseAddress = 32'hFFFF_FFF0 with cause 19 -> vectorAddress = 32'h0000_003C.
- syncException in ACTIVE together with returnFromInterrupt -> FAULT, doubleFault = 1, cause = 31, stays until reset.
- With IRQ_LATCH_EN: a 1-cycle irq[0] pulse during ACTIVE, then reti -> taken after the next instructionDone, cause = 16.

Source files
------------

// File: rtl/exception_controller_if.sv
// Signal bundle between the exception controller and the core (execute, system block, fetch).
// The master modport is the controller side; the slave modport is the core side.
interface exception_controller_if #(
  parameter int NUM_IRQ  = 16,
  parameter int NUM_SYNC = 4
);
  logic [NUM_IRQ-1:0]  irq;
  logic [NUM_SYNC-1:0] syncException;
  logic                interruptEnable;
  logic [15:0]         exceptionMask;
  logic [31:0]         isrBaseAddress;
  logic                instructionDone;
  logic                returnFromInterrupt;
  logic                vectorAck;
  logic                exceptionPending;
  logic [4:0]          cause;
  logic                vectorValid;
  logic [31:0]         vectorAddress;
  logic                clearInterruptEnable;
  logic                inHandler;
  logic                doubleFault;

  modport master (
    input  irq, syncException, interruptEnable, exceptionMask, isrBaseAddress,
           instructionDone, returnFromInterrupt, vectorAck,
    output exceptionPending, cause, vectorValid, vectorAddress,
           clearInterruptEnable, inHandler, doubleFault
  );

  modport slave (
    output irq, syncException, interruptEnable, exceptionMask, isrBaseAddress,
           instructionDone, returnFromInterrupt, vectorAck,
    input  exceptionPending, cause, vectorValid, vectorAddress,
           clearInterruptEnable, inHandler, doubleFault
  );
endinterface

// File: rtl/exception_controller.sv
// Exception/interrupt entry sequencer for cpu32e2: priority, cause, vector handshake, one nesting level.
// Optional macro IRQ_LATCH_EN: interrupt lines become rising-edge latched pending bits.
module exception_controller #(
  parameter int NUM_IRQ      = 16,
  parameter int NUM_SYNC     = 4,
  parameter int VECTOR_SHIFT = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  exception_controller_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_VECTOR  = 3'd2,
    ST_ACTIVE  = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

  localparam logic [4:0] CAUSE_FAULT = 5'd31;

  function automatic logic [3:0] f_lowest_idx(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) begin
        idx = 4'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  function automatic logic [31:0] f_vector_address(input logic [31:0] base, input logic [4:0] c);
    logic [31:0] offset;
    offset = {27'd0, c} << VECTOR_SHIFT;
    return base + offset;
  endfunction

  state_t      r_state;
  logic        r_exception_pending;
  logic [4:0]  r_cause;
  logic        r_vector_valid;
  logic [31:0] r_vector_address;
  logic        r_clear_inten;
  logic        r_in_handler;
  logic        r_double_fault;

  logic [NUM_IRQ-1:0] w_irq_src;
  logic [15:0]        w_sync_ext;
  logic [15:0]        w_irq_ext;
  logic [15:0]        w_irq_elig;
  logic               w_sync_any;
  logic               w_irq_any;
  logic               w_take_sync;
  logic               w_take_irq;
  logic [3:0]         w_sync_idx;
  logic [3:0]         w_irq_idx;

`ifdef IRQ_LATCH_EN
  logic [NUM_IRQ-1:0] r_irq_prev;
  logic [NUM_IRQ-1:0] r_irq_pend;
  logic [15:0]        w_irq_clr16;
  logic [NUM_IRQ-1:0] w_irq_clr;

  assign w_irq_clr16 = 16'h0001 << w_irq_idx;
  assign w_irq_clr   = w_irq_clr16[NUM_IRQ-1:0] & {NUM_IRQ{w_take_irq}};
  assign w_irq_src   = r_irq_pend;

  // Rising edges accumulate in every state; the dispatched line clears as it is captured.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq_prev <= '0;
      r_irq_pend <= '0;
    end else begin
      r_irq_prev <= bus.irq;
      r_irq_pend <= (r_irq_pend & ~w_irq_clr) | (bus.irq & ~r_irq_prev);
    end
  end
`else
  assign w_irq_src = bus.irq;
`endif

  always_comb begin
    w_sync_ext = 16'h0000;
    w_irq_ext  = 16'h0000;
    w_sync_ext[NUM_SYNC-1:0] = bus.syncException;
    w_irq_ext[NUM_IRQ-1:0]   = w_irq_src;
  end

  assign w_irq_elig  = w_irq_ext & bus.exceptionMask & {16{bus.interruptEnable}};
  assign w_sync_any  = |w_sync_ext;
  assign w_irq_any   = |w_irq_elig;
  assign w_sync_idx  = f_lowest_idx(w_sync_ext);
  assign w_irq_idx   = f_lowest_idx(w_irq_elig);
  // Sync exceptions abort immediately; interrupts wait for an instruction boundary.
  assign w_take_sync = (r_state == ST_IDLE) && w_sync_any;
  assign w_take_irq  = (r_state == ST_IDLE) && !w_sync_any && w_irq_any && bus.instructionDone;

  // Entry sequencer; every output is registered on the transition into the state that owns it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state             <= ST_IDLE;
      r_exception_pending <= 1'b0;
      r_cause             <= 5'd0;
      r_vector_valid      <= 1'b0;
      r_vector_address    <= 32'd0;
      r_clear_inten       <= 1'b0;
      r_in_handler        <= 1'b0;
      r_double_fault      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_take_sync) begin
            r_state             <= ST_CAPTURE;
            r_cause             <= {1'b0, w_sync_idx};
            r_vector_address    <= f_vector_address(bus.isrBaseAddress, {1'b0, w_sync_idx});
            r_exception_pending <= 1'b1;
            r_clear_inten       <= 1'b1;
          end else if (w_take_irq) begin
            r_state             <= ST_CAPTURE;
            r_cause             <= {1'b1, w_irq_idx};
            r_vector_address    <= f_vector_address(bus.isrBaseAddress, {1'b1, w_irq_idx});
            r_exception_pending <= 1'b1;
            r_clear_inten       <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_CAPTURE: begin
          r_state        <= ST_VECTOR;
          r_clear_inten  <= 1'b0;
          r_vector_valid <= 1'b1;
        end
        ST_VECTOR: begin
          if (bus.vectorAck) begin
            r_state             <= ST_ACTIVE;
            r_vector_valid      <= 1'b0;
            r_exception_pending <= 1'b0;
            r_in_handler        <= 1'b1;
          end else begin
            r_state <= ST_VECTOR;
          end
        end
        ST_ACTIVE: begin
          if (|bus.syncException) begin
            r_state             <= ST_FAULT;
            r_double_fault      <= 1'b1;
            r_exception_pending <= 1'b1;
            r_cause             <= CAUSE_FAULT;
            r_in_handler        <= 1'b0;
          end else if (bus.returnFromInterrupt) begin
            r_state      <= ST_IDLE;
            r_in_handler <= 1'b0;
          end else begin
            r_state <= ST_ACTIVE;
          end
        end
        ST_FAULT: begin
          r_state <= ST_FAULT;
        end
        default: begin
          r_state             <= ST_IDLE;
          r_exception_pending <= 1'b0;
          r_vector_valid      <= 1'b0;
          r_clear_inten       <= 1'b0;
          r_in_handler        <= 1'b0;
        end
      endcase
    end
  end

  assign bus.exceptionPending     = r_exception_pending;
  assign bus.cause                = r_cause;
  assign bus.vectorValid          = r_vector_valid;
  assign bus.vectorAddress        = r_vector_address;
  assign bus.clearInterruptEnable = r_clear_inten;
  assign bus.inHandler            = r_in_handler;
  assign bus.doubleFault          = r_double_fault;

endmodule

// File: tb/tb_exception_controller.sv
// Scoreboard bench for exception_controller: expected cause/vector pushed at stimulus, popped at vectorValid.
module tb_exception_controller;

  typedef struct {
    logic [4:0]  cause;
    logic [31:0] addr;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  exp_t sb[$];

  exception_controller_if #(.NUM_IRQ(16), .NUM_SYNC(4)) bus ();

  exception_controller #(.NUM_IRQ(16), .NUM_SYNC(4), .VECTOR_SHIFT(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [4:0] c, input logic [31:0] a);
    exp_t e;
    e.cause = c;
    e.addr  = a;
    sb.push_back(e);
  endtask

  task automatic take_vector(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (!bus.vectorValid && n < 20) begin
      tick();
      n++;
    end
    check_eq({tag, "_valid"}, {31'd0, bus.vectorValid}, 32'd1);
    if (bus.vectorValid) begin
      check_eq({tag, "_sb"}, sb.size(), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_eq({tag, "_cause"}, {27'd0, bus.cause}, {27'd0, e.cause});
        check_eq({tag, "_addr"}, bus.vectorAddress, e.addr);
      end
      bus.vectorAck = 1'b1;
      tick();
      bus.vectorAck = 1'b0;
      check_eq({tag, "_inh"}, {31'd0, bus.inHandler}, 32'd1);
      check_eq({tag, "_pend_off"}, {31'd0, bus.exceptionPending}, 32'd0);
    end
  endtask

  task automatic do_reti(input string tag);
    bus.returnFromInterrupt = 1'b1;
    tick();
    bus.returnFromInterrupt = 1'b0;
    check_eq({tag, "_reti"}, {31'd0, bus.inHandler}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    bus.irq = 16'h0000;
    bus.syncException = 4'h0;
    bus.interruptEnable = 1'b0;
    bus.exceptionMask = 16'h0000;
    bus.isrBaseAddress = 32'h0000_1000;
    bus.instructionDone = 1'b0;
    bus.returnFromInterrupt = 1'b0;
    bus.vectorAck = 1'b0;
    do_reset();

    check_eq("rst_pend", {31'd0, bus.exceptionPending}, 32'd0);
    check_eq("rst_cause", {27'd0, bus.cause}, 32'd0);
    check_eq("rst_valid", {31'd0, bus.vectorValid}, 32'd0);
    check_eq("rst_addr", bus.vectorAddress, 32'd0);
    check_eq("rst_clr", {31'd0, bus.clearInterruptEnable}, 32'd0);
    check_eq("rst_df", {31'd0, bus.doubleFault}, 32'd0);

    // Sync exception 2: latency and single clear pulse
    bus.syncException = 4'b0100;
    push_exp(5'd2, 32'h0000_1008);
    tick();
    bus.syncException = 4'b0000;
    check_eq("t1_pend_n1", {31'd0, bus.exceptionPending}, 32'd1);
    check_eq("t1_valid_n1", {31'd0, bus.vectorValid}, 32'd0);
    check_eq("t1_clr_n1", {31'd0, bus.clearInterruptEnable}, 32'd1);
    tick();
    check_eq("t1_valid_n2", {31'd0, bus.vectorValid}, 32'd1);
    check_eq("t1_clr_n2", {31'd0, bus.clearInterruptEnable}, 32'd0);
    take_vector("t1");
    do_reti("t1");

    // IRQ 3 only taken at an instruction boundary; deasserting afterwards does not cancel
    bus.irq = 16'h0008;
    bus.exceptionMask = 16'h0008;
    bus.interruptEnable = 1'b1;
    tick();
    check_eq("t2_no_boundary", {31'd0, bus.exceptionPending}, 32'd0);
    bus.instructionDone = 1'b1;
    push_exp(5'd19, 32'h0000_104C);
    tick();
    bus.instructionDone = 1'b0;
    bus.irq = 16'h0000;
    check_eq("t2_pend", {31'd0, bus.exceptionPending}, 32'd1);
    take_vector("t2");
    do_reti("t2");

    // Sync beats interrupts
    bus.irq = 16'h0028;
    bus.exceptionMask = 16'hFFFF;
    bus.syncException = 4'b0010;
    bus.instructionDone = 1'b1;
    push_exp(5'd1, 32'h0000_1004);
    tick();
    bus.syncException = 4'b0000;
    bus.instructionDone = 1'b0;
    take_vector("t3");
    bus.irq = 16'h0000;
    do_reti("t3");

    // Interrupts disabled: nothing is ever taken
    bus.interruptEnable = 1'b0;
    bus.irq = 16'h0028;
    bus.instructionDone = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq("t3_inten_off", {31'd0, bus.exceptionPending}, 32'd0);
    end
    bus.irq = 16'h0000;
    bus.instructionDone = 1'b0;

    // Wrapping vector address and stable offer while ack is held low
    bus.interruptEnable = 1'b1;
    bus.exceptionMask = 16'h0008;
    bus.irq = 16'h0008;
    bus.isrBaseAddress = 32'hFFFF_FFF0;
    bus.instructionDone = 1'b1;
    push_exp(5'd19, 32'h0000_003C);
    tick();
    bus.instructionDone = 1'b0;
    bus.irq = 16'h0000;
    tick();
    for (int i = 0; i < 5; i++) begin
      bus.isrBaseAddress = 32'h1234_0000 + 32'(i);
      bus.syncException = 4'b0001;
      tick();
      check_eq("t4_hold_valid", {31'd0, bus.vectorValid}, 32'd1);
      check_eq("t4_hold_addr", bus.vectorAddress, 32'h0000_003C);
    end
    bus.syncException = 4'b0000;
    take_vector("t4");

    // Sync in ACTIVE beats reti: sticky double fault
    bus.syncException = 4'b1000;
    bus.returnFromInterrupt = 1'b1;
    tick();
    bus.syncException = 4'b0000;
    bus.returnFromInterrupt = 1'b0;
    check_eq("t5_df", {31'd0, bus.doubleFault}, 32'd1);
    check_eq("t5_cause", {27'd0, bus.cause}, 32'd31);
    check_eq("t5_pend", {31'd0, bus.exceptionPending}, 32'd1);
    bus.returnFromInterrupt = 1'b1;
    bus.irq = 16'h0008;
    bus.instructionDone = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    bus.returnFromInterrupt = 1'b0;
    bus.irq = 16'h0000;
    bus.instructionDone = 1'b0;
    check_eq("t5_df_sticky", {31'd0, bus.doubleFault}, 32'd1);
    check_eq("t5_cause_sticky", {27'd0, bus.cause}, 32'd31);
    do_reset();
    check_eq("t5_df_cleared", {31'd0, bus.doubleFault}, 32'd0);
    check_eq("t5_cause_cleared", {27'd0, bus.cause}, 32'd0);

    // One-cycle irq[0] pulse during ACTIVE: remembered only with line latching
    bus.isrBaseAddress = 32'h0000_2000;
    bus.exceptionMask = 16'h0001;
    bus.interruptEnable = 1'b1;
    bus.syncException = 4'b0001;
    push_exp(5'd0, 32'h0000_2000);
    tick();
    bus.syncException = 4'b0000;
    take_vector("t6a");
    bus.irq = 16'h0001;
    tick();
    bus.irq = 16'h0000;
    tick();
    do_reti("t6");
    tick();
    check_eq("t6_wait_boundary", {31'd0, bus.exceptionPending}, 32'd0);
    bus.instructionDone = 1'b1;
`ifdef IRQ_LATCH_EN
    push_exp(5'd16, 32'h0000_2040);
    tick();
    bus.instructionDone = 1'b0;
    take_vector("t6b");
    do_reti("t6b");
`else
    tick();
    bus.instructionDone = 1'b0;
    check_eq("t6_level_drop", {31'd0, bus.exceptionPending}, 32'd0);
    tick();
    check_eq("t6_level_novec", {31'd0, bus.vectorValid}, 32'd0);
`endif
    check_eq("sb_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
